// File: rtl/bravo_dec_ctrl.sv
// Front-panel controller for an external DES decrypt core: byte entry, latency wait, windowed display.
// Optional build macro BRAVO_CT_ECHO_EN echoes the ciphertext on the display while bytes are entered.
module bravo_dec_ctrl #(
  parameter int          DES_LATENCY = 17,
  parameter logic [15:0] DISP_RESET  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        pb_load,
  input  logic        pb_go,
  input  logic        pb_sel,
  input  logic        pb_clr,
  output logic [63:0] des_in,
  input  logic [63:0] des_out,
  output logic [15:0] disp_data,
  output logic [3:0]  disp_dp,
  output logic [7:0]  led,
  output logic        done
);

  localparam int LW = (DES_LATENCY > 1) ? $clog2(DES_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DECRYPT = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [63:0]   ct, ct_n, pt, pt_n;
  logic [3:0]    count, count_n;
  logic [1:0]    window, window_n;
  logic [LW-1:0] lat, lat_n;
  logic [3:0]    hist;
  logic          ev_load, ev_go, ev_sel, ev_clr;
  logic [63:0]   des_in_n;
  logic [15:0]   disp_data_n;
  logic [3:0]    disp_dp_n;
  logic [7:0]    led_n;
  logic          done_n;

  function automatic logic [15:0] pick16(input logic [63:0] v, input logic [1:0] w);
    case (w)
      2'd0:    pick16 = v[15:0];
      2'd1:    pick16 = v[31:16];
      2'd2:    pick16 = v[47:32];
      default: pick16 = v[63:48];
    endcase
  endfunction

  // Byte n lands at [63-8n -: 8], so the first byte entered is the most significant.
  function automatic logic [63:0] put_byte(input logic [63:0] v, input logic [3:0] n,
                                           input logic [7:0] b);
    put_byte = v;
    for (int i = 0; i < 8; i++)
      if (n == 4'(i)) put_byte[63-8*i -: 8] = b;
  endfunction

  always_comb begin
    ev_load = pb_load & ~hist[0];
    ev_go   = pb_go   & ~hist[1];
    ev_sel  = pb_sel  & ~hist[2];
    ev_clr  = pb_clr  & ~hist[3];

    state_n  = state;
    ct_n     = ct;
    pt_n     = pt;
    count_n  = count;
    window_n = window;
    lat_n    = lat;

    if (ev_clr) begin
      state_n  = IDLE;
      ct_n     = '0;
      pt_n     = '0;
      count_n  = '0;
      window_n = '0;
      lat_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_load) begin
            ct_n    = put_byte(ct, count, sw);
            count_n = count + 4'd1;
            state_n = LOAD;
          end
        end
        LOAD: begin
          // A load event swallows a simultaneous go event, even when the load itself is ignored.
          if (ev_load) begin
            if (count != 4'd8) begin
              ct_n    = put_byte(ct, count, sw);
              count_n = count + 4'd1;
            end
          end else if (ev_go && count == 4'd8) begin
            state_n = DECRYPT;
            lat_n   = LW'(DES_LATENCY - 1);
          end
`ifdef BRAVO_CT_ECHO_EN
          if (ev_sel) window_n = window + 2'd1;
`endif
        end
        DECRYPT: begin
          if (lat == '0) begin
            pt_n     = des_out;
            state_n  = SHOW;
            window_n = '0;
          end else begin
            lat_n = lat - LW'(1);
          end
        end
        SHOW: begin
          if (ev_load) begin
            ct_n     = {sw, 56'h0};
            count_n  = 4'd1;
            window_n = '0;
            state_n  = LOAD;
          end else if (ev_sel) begin
            window_n = window + 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Outputs are derived from next-state values so the registered outputs track the state exactly.
    des_in_n    = ct_n;
    done_n      = (state_n == SHOW);
    led_n       = {2'b00, state_n, 1'b0, count_n[2:0]};
    disp_data_n = DISP_RESET;
    disp_dp_n   = 4'hF;
    if (state_n == SHOW) begin
      disp_data_n = pick16(pt_n, window_n);
      disp_dp_n   = ~(4'b0001 << window_n);
    end
`ifdef BRAVO_CT_ECHO_EN
    else if (state_n == LOAD) begin
      disp_data_n = pick16(ct_n, window_n);
      disp_dp_n   = ~(4'b0001 << window_n);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ct        <= '0;
      pt        <= '0;
      count     <= '0;
      window    <= '0;
      lat       <= '0;
      hist      <= '0;
      des_in    <= '0;
      disp_data <= DISP_RESET;
      disp_dp   <= 4'hF;
      led       <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ct        <= ct_n;
      pt        <= pt_n;
      count     <= count_n;
      window    <= window_n;
      lat       <= lat_n;
      hist      <= {pb_clr, pb_sel, pb_go, pb_load};
      des_in    <= des_in_n;
      disp_data <= disp_data_n;
      disp_dp   <= disp_dp_n;
      led       <= led_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_bravo_dec_ctrl.sv
// Self-checking bench for bravo_dec_ctrl: a front-panel behavioural model checked every cycle,
// plus directed literal checks. Define BRAVO_CT_ECHO_EN for both DUT and bench to cover the echo build.
module tb_bravo_dec_ctrl;

  localparam int          LAT   = 17;
  localparam logic [15:0] DRST  = 16'h0000;
  localparam logic [63:0] KEYCT = 64'h85E813540F0AB405;
  localparam logic [63:0] KEYPT = 64'h0123456789ABCDEF;

  logic        clk, rst_n;
  logic [7:0]  sw;
  logic        pb_load, pb_go, pb_sel, pb_clr;
  logic [63:0] des_in, des_out;
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  logic [7:0]  led;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Bench-side model of the panel: entered bytes, mode, display window and remaining wait.
  int         m_state;
  logic [7:0] m_bytes[$];
  logic [63:0] m_pt;
  int         m_win;
  int         m_remain;
  logic [3:0] m_hist;

`ifdef BRAVO_CT_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  bravo_dec_ctrl #(.DES_LATENCY(LAT), .DISP_RESET(DRST)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .pb_load(pb_load), .pb_go(pb_go),
    .pb_sel(pb_sel), .pb_clr(pb_clr), .des_in(des_in), .des_out(des_out),
    .disp_data(disp_data), .disp_dp(disp_dp), .led(led), .done(done)
  );

  function automatic logic [63:0] des_fn(input logic [63:0] c);
    if (c == KEYCT) return KEYPT;
    return {c[31:0], ~c[63:32]};
  endfunction

  assign des_out = des_fn(des_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] m_ct();
    logic [63:0] v = '0;
    for (int i = 0; i < m_bytes.size(); i++)
      v = v | (64'(m_bytes[i]) << (56 - 8 * i));
    return v;
  endfunction

  function automatic logic [15:0] m_disp();
    logic [63:0] src;
    if (m_state == 3) src = m_pt;
    else if (ECHO && m_state == 1) src = m_ct();
    else return DRST;
    return 16'(src >> (16 * m_win));
  endfunction

  function automatic logic [3:0] m_dp();
    if (m_state == 3 || (ECHO && m_state == 1)) return ~(4'b0001 << m_win);
    return 4'hF;
  endfunction

  function automatic logic [7:0] m_led();
    return 8'((m_state << 4) | (m_bytes.size() % 8));
  endfunction

  task automatic model_reset();
    m_state = 0; m_bytes = {}; m_pt = '0; m_win = 0; m_remain = 0;
  endtask

  task automatic model_step();
    logic [3:0] cur, ev;
    cur    = {pb_clr, pb_sel, pb_go, pb_load};
    ev     = cur & ~m_hist;
    m_hist = cur;
    if (ev[3]) begin
      model_reset();
    end else begin
      case (m_state)
        0: if (ev[0]) begin m_bytes.push_back(sw); m_state = 1; end
        1: begin
          if (ev[0]) begin
            if (m_bytes.size() < 8) m_bytes.push_back(sw);
          end else if (ev[1] && m_bytes.size() == 8) begin
            m_state = 2; m_remain = LAT;
          end
          if (ECHO && ev[2]) m_win = (m_win + 1) % 4;
        end
        2: begin
          m_remain--;
          if (m_remain == 0) begin m_pt = des_fn(m_ct()); m_state = 3; m_win = 0; end
        end
        default: begin
          if (ev[0]) begin m_bytes = {sw}; m_state = 1; m_win = 0; end
          else if (ev[2]) m_win = (m_win + 1) % 4;
        end
      endcase
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every-cycle comparison against the model, half a cycle after the outputs settle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("des_in", des_in, m_ct());
      check_output("disp_data", 64'(disp_data), 64'(m_disp()));
      check_output("disp_dp", 64'(disp_dp), 64'(m_dp()));
      check_output("led", 64'(led), 64'(m_led()));
      check_output("done", 64'(done), 64'(m_state == 3));
    end
  end

  task automatic apply_stimulus(input logic ld, input logic go, input logic sl,
                                input logic cl, input logic [7:0] b);
    pb_load = ld; pb_go = go; pb_sel = sl; pb_clr = cl; sw = b;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 8'h00);
  endtask

  task automatic press_load(input logic [7:0] b);
    apply_stimulus(1, 0, 0, 0, b);
    apply_stimulus(0, 0, 0, 0, b);
  endtask

  task automatic press_go();  apply_stimulus(0, 1, 0, 0, 8'h00); idle(1); endtask
  task automatic press_sel(); apply_stimulus(0, 0, 1, 0, 8'h00); idle(1); endtask
  task automatic press_clr(); apply_stimulus(0, 0, 0, 1, 8'h00); idle(1); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pb_load = 0; pb_go = 0; pb_sel = 0; pb_clr = 0; sw = '0;
    model_reset();
    m_hist = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic enter_key();
    logic [63:0] k = KEYCT;
    for (int i = 0; i < 8; i++) press_load(k[63-8*i -: 8]);
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    check_output("reset_led", 64'(led), 64'h00);
    check_output("reset_disp", 64'(disp_data), 64'(DRST));
    check_output("reset_dp", 64'(disp_dp), 64'hF);

    // Main flow: key bytes, go, fixed latency, then walk the display window.
    enter_key();
    check_output("key_led", 64'(led), 64'h10);
    check_output("key_ct", des_in, KEYCT);
    press_go();
    idle(15);
    check_output("lat_done_early", 64'(done), 64'h0);
    idle(1);
    check_output("lat_done", 64'(done), 64'h1);
    check_output("win0", 64'(disp_data), 64'hCDEF);
    check_output("win0_dp", 64'(disp_dp), 64'hE);
    press_sel(); check_output("win1", 64'(disp_data), 64'h89AB);
    press_sel(); check_output("win2", 64'(disp_data), 64'h4567);
    press_sel(); check_output("win3", 64'(disp_data), 64'h0123);
    check_output("win3_dp", 64'(disp_dp), 64'h7);
    press_sel(); check_output("win_wrap", 64'(disp_data), 64'hCDEF);

    // New entry from SHOW restarts the ciphertext; a held button counts once.
    apply_stimulus(1, 0, 0, 0, 8'hAA);
    idle(3);
    apply_stimulus(1, 0, 0, 0, 8'hBB);
    apply_stimulus(1, 0, 0, 0, 8'hBB);
    apply_stimulus(1, 0, 0, 0, 8'hBB);
    idle(1);
    check_output("show_reload_ct", des_in, 64'hAABB000000000000);
    check_output("show_reload_led", 64'(led), 64'h12);
    press_clr();
    check_output("clr_show_led", 64'(led), 64'h00);

    // Saturation at eight bytes; go with seven bytes is ignored.
    do_reset();
    for (int i = 1; i <= 9; i++) press_load(8'(i));
    check_output("sat_led", 64'(led), 64'h10);
    check_output("sat_ct", des_in, 64'h0102030405060708);
    do_reset();
    for (int i = 1; i <= 7; i++) press_load(8'(i));
    press_go();
    idle(3);
    check_output("go7_led", 64'(led), 64'h17);

    // Load and go on the same edge with eight bytes: go is lost.
    press_load(8'h08);
    apply_stimulus(1, 1, 0, 0, 8'h99);
    idle(LAT + 4);
    check_output("ldgo_led", 64'(led), 64'h10);
    check_output("ldgo_done", 64'(done), 64'h0);

    // Clear at cycle 5 of DECRYPT abandons the decryption.
    do_reset();
    enter_key();
    press_go();
    idle(3);
    press_clr();
    check_output("clr_led", 64'(led), 64'h00);
    check_output("clr_disp", 64'(disp_data), 64'h0000);
    idle(LAT + 5);
    check_output("clr_nocap", 64'(done), 64'h0);

    // Asynchronous reset mid-DECRYPT.
    do_reset();
    enter_key();
    press_go();
    idle(4);
    do_reset();
    check_output("rst_led", 64'(led), 64'h00);
    idle(LAT + 5);
    check_output("rst_nocap", 64'(done), 64'h0);
    check_output("rst_disp", 64'(disp_data), 64'h0000);

`ifdef BRAVO_CT_ECHO_EN
    do_reset();
    press_load(8'h85);
    press_load(8'hE8);
    check_output("echo_w0", 64'(disp_data), 64'h0000);
    press_sel(); press_sel(); press_sel();
    check_output("echo_w3", 64'(disp_data), 64'h85E8);
    check_output("echo_dp", 64'(disp_dp), 64'h7);
`else
    do_reset();
    press_load(8'h85);
    press_sel();
    check_output("noecho_dp", 64'(disp_dp), 64'hF);
`endif

    idle(2);
    chk_en = 0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bravo_dec_ctrl.md
BRAVO_DEC_CTRL -- requirements
Module: bravo_dec_ctrl

Interface
REQ-001 SHALL have parameter DES_LATENCY, default 17: clock cycles from des_in stable to des_out valid.
REQ-002 SHALL have parameter DISP_RESET, default 16'h0000: disp_data value whenever no data is shown.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sw  input  8  ciphertext byte entry from the slide switches.
REQ-006 SHALL have port pb_load  input  1  button: store the byte on sw.
REQ-007 SHALL have port pb_go  input  1  button: start decryption.
REQ-008 SHALL have port pb_sel  input  1  button: advance the display 16-bit window.
REQ-009 SHALL have port pb_clr  input  1  button: synchronous clear to IDLE.
REQ-010 SHALL have port des_in  output  64  ciphertext to the external DES decrypt core.
REQ-011 SHALL have port des_out  input  64  plaintext from the DES decrypt core.
REQ-012 SHALL have port disp_data  output  16  4-hex-digit value for the 7-segment driver.
REQ-013 SHALL have port disp_dp  output  4  decimal points, active-low, one-hot low marks the window.
REQ-014 SHALL have port led  output  8  byte count in [2:0], state code in [5:4], 0 elsewhere.
REQ-015 SHALL have port done  output  1  high while the plaintext is held for display.

Function
REQ-016 SHALL edge-detect each button with one history register per button; only a 0->1 edge is an event.
REQ-017 SHALL implement states IDLE(0), LOAD(1), DECRYPT(2), SHOW(3) and drive the code on led[5:4].
REQ-018 SHALL, on a pb_load event in IDLE, LOAD or SHOW, write sw to ct[63-8n -: 8], where n = byte count; the first byte goes to [63:56].
REQ-019 SHALL increment the byte count on each store; the count saturates at 8, and further pb_load events while the count is 8 are ignored.
REQ-020 SHALL, on a pb_load event in SHOW, clear ct, store the byte at [63:56], set the count to 1, and enter LOAD.
REQ-021 SHALL, on a pb_go event in LOAD with count==8, enter DECRYPT and load the latency counter with DES_LATENCY-1; pb_go is ignored at any other time.
REQ-022 SHALL drive des_in = ct continuously; ct SHALL NOT change during DECRYPT.
REQ-023 SHALL decrement the latency counter each cycle in DECRYPT; at zero it SHALL capture des_out into pt, enter SHOW, assert done, and set window=0.
REQ-024 SHALL ignore pb_load and pb_sel during DECRYPT.
REQ-025 SHALL advance window (2 bits, wraps 3->0) on a pb_sel event in SHOW.
REQ-026 SHALL, in SHOW, output disp_data = pt[15:0], [31:16], [47:32], [63:48] for window 0..3, with disp_dp = ~4'h1, ~4'h2, ~4'h4, ~4'h8 respectively.
REQ-027 SHALL give pb_clr priority over all other events in the same cycle: it returns the block to the reset state without waiting for DECRYPT to finish.
REQ-028 SHALL act only on pb_load when pb_load and pb_go events occur in the same cycle in LOAD; that pb_go is lost.
REQ-029 SHALL register all outputs.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: state=IDLE, ct=0, pt=0, count=0, window=0, latency counter=0, button history=0, des_in=0, disp_data=DISP_RESET, disp_dp=4'hF, led=0, done=0.
REQ-031 SHALL discard any in-flight decryption when rst_n is asserted mid-DECRYPT; no capture occurs after release.

Configuration
REQ-032 SHALL, with BRAVO_CT_ECHO_EN defined, display ct in LOAD using the same window/disp_dp mapping, with pb_sel active in LOAD.
REQ-033 SHALL, without BRAVO_CT_ECHO_EN, output DISP_RESET and disp_dp=4'hF in IDLE, LOAD and DECRYPT, and ignore pb_sel outside SHOW.

Verification
REQ-034 Enter bytes 85,E8,13,54,0F,0A,B4,05, then pb_go; the DES model returns 0123456789ABCDEF -> exactly 17 cycles after the pb_go edge is registered: done=1 and disp_data=CDEF; three pb_sel events -> 89AB, 4567, 0123; a fourth -> CDEF.
REQ-035 Enter 9 pb_load events -> led[2:0]=0 (count 8 saturated) and ct equals the first 8 bytes; pb_go after only 7 bytes -> state stays LOAD.
REQ-036 pb_clr or rst_n low at cycle 5 of DECRYPT -> IDLE, done=0, disp_data=0000, and no later capture.
REQ-037 pb_load and pb_go in the same cycle with count 8 -> count stays 8, state stays LOAD, no DECRYPT.
REQ-038 With BRAVO_CT_ECHO_EN defined, after entering 85,E8 -> disp_data=0000 in window 0, and in window 3 disp_data=85E8 with disp_dp=4'h7.
